// File: rtl/lc3b_victim_buffer_pkg.sv
// Shared LC-3b memory-side types used by the L1 write-back victim buffer.
package lc3b_victim_buffer_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [11:0]  lc3b_wb_adr;
  typedef logic [127:0] lc3b_line;

  typedef enum logic {
    vb_idle,
    vb_drain
  } lc3b_vb_state;

endpackage

// File: rtl/lc3b_vb_match.sv
// DEPTH-way line address compare; among several matches the entry written most
// recently (closest behind the tail pointer) is selected.
module lc3b_vb_match
  import lc3b_victim_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = 2
) (
  input  logic [DEPTH-1:0] valid,
  input  lc3b_wb_adr       adr  [DEPTH],
  input  lc3b_line         data [DEPTH],
  input  logic [PW-1:0]    tail,
  input  lc3b_wb_adr       key,
  output logic             hit,
  output logic [PW-1:0]    idx,
  output lc3b_line         hit_data
);

  logic [DEPTH-1:0] eq;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign eq[gi] = valid[gi] && (adr[gi] == key);
    end
  endgenerate

  // Walk from oldest (tail) to newest (tail-1); the last match seen wins.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (eq[(int'(tail) + k) % DEPTH]) begin
        hit = 1'b1;
        idx = PW'((int'(tail) + k) % DEPTH);
      end
    end
    hit_data = hit ? data[idx] : '0;
  end

endmodule

// File: rtl/lc3b_victim_buffer.sv
// Write-back victim buffer: queues evicted dirty lines, drains them to memory in
// FIFO order and keeps them visible to the cache through a lookup port.
module lc3b_victim_buffer
  import lc3b_victim_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vb_push,
  input  lc3b_wb_adr vb_push_adr,
  input  lc3b_line   vb_push_data,
  output logic       vb_full,
  output logic       vb_empty,
  input  lc3b_wb_adr lk_adr,
  output logic       lk_hit,
  output lc3b_line   lk_data,
  input  logic       drain_hold,
  output logic       pmem_write,
  output lc3b_word   pmem_address,
  output lc3b_line   pmem_wdata,
  input  logic       pmem_resp
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] valid_q, valid_d;
  lc3b_wb_adr       adr_q  [DEPTH];
  lc3b_wb_adr       adr_d  [DEPTH];
  lc3b_line         data_q [DEPTH];
  lc3b_line         data_d [DEPTH];
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  lc3b_vb_state     state_q, state_d;

  logic             push_ok, push_new, pop;
  logic [DEPTH-1:0] coal_valid;
  logic             coal_hit;
  logic [PW-1:0]    coal_idx;
  lc3b_line         coal_data;
  logic [PW-1:0]    lk_idx;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // The head being written to memory must not change underneath the drain.
  assign coal_valid = valid_q & ~((state_q == vb_drain) ? (DEPTH'(1) << head_q) : '0);

  lc3b_vb_match #(.DEPTH(DEPTH), .PW(PW)) u_coal_match (
    .valid(coal_valid), .adr(adr_q), .data(data_q), .tail(tail_q),
    .key(vb_push_adr), .hit(coal_hit), .idx(coal_idx), .hit_data(coal_data)
  );

  lc3b_vb_match #(.DEPTH(DEPTH), .PW(PW)) u_lk_match (
    .valid(valid_q), .adr(adr_q), .data(data_q), .tail(tail_q),
    .key(lk_adr), .hit(lk_hit), .idx(lk_idx), .hit_data(lk_data)
  );

  assign vb_full  = (count_q == CW'(DEPTH));
  assign vb_empty = (count_q == '0);
  assign push_ok  = vb_push && !vb_full;
  assign push_new = push_ok && !coal_hit;
  assign pop      = (state_q == vb_drain) && pmem_resp;

  always_comb begin
    valid_d = valid_q;
    adr_d   = adr_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = ptr_inc(head_q);
    end
    if (push_ok) begin
      if (coal_hit) begin
        data_d[coal_idx] = vb_push_data;
      end else begin
        valid_d[tail_q] = 1'b1;
        adr_d[tail_q]   = vb_push_adr;
        data_d[tail_q]  = vb_push_data;
        tail_d          = ptr_inc(tail_q);
      end
    end
    count_d = count_q + CW'(push_new) - CW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    adr_q  <= adr_d;
    data_q <= data_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= vb_idle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      vb_idle:  if ((count_q != '0) && !drain_hold) state_d = vb_drain;
      vb_drain: if (pmem_resp) state_d = vb_idle;
      default:  state_d = vb_idle;
    endcase
  end

  // Head entry is frozen during a drain, so these follow registers only.
  always_comb begin
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    if (state_q == vb_drain) begin
      pmem_write   = 1'b1;
      pmem_address = {adr_q[head_q], 4'b0000};
      pmem_wdata   = data_q[head_q];
    end
  end

endmodule

// File: tb/tb_lc3b_victim_buffer.sv
// Directed bench for lc3b_victim_buffer (DEPTH=4) with hand-computed expectations.
module tb_lc3b_victim_buffer;
  import lc3b_victim_buffer_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vb_push = 1'b0;
  lc3b_wb_adr vb_push_adr = '0;
  lc3b_line   vb_push_data = '0;
  logic       vb_full, vb_empty;
  lc3b_wb_adr lk_adr = '0;
  logic       lk_hit;
  lc3b_line   lk_data;
  logic       drain_hold = 1'b0;
  logic       pmem_write;
  lc3b_word   pmem_address;
  lc3b_line   pmem_wdata;
  logic       pmem_resp = 1'b0;

  int passed = 0;
  int total  = 0;

  localparam lc3b_line DATA_1  = 128'hDEAD0000_11112222_33334444_0000BEEF;
  localparam lc3b_line DATA_A  = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
  localparam lc3b_line DATA_B  = 128'hBBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB;
  localparam lc3b_line DATA_C  = 128'hCCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC;
  localparam lc3b_line DATA_X  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  lc3b_victim_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .vb_push(vb_push), .vb_push_adr(vb_push_adr), .vb_push_data(vb_push_data),
    .vb_full(vb_full), .vb_empty(vb_empty),
    .lk_adr(lk_adr), .lk_hit(lk_hit), .lk_data(lk_data),
    .drain_hold(drain_hold),
    .pmem_write(pmem_write), .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic lc3b_line pat(input int i);
    return {4{32'hC0DE0000 + 32'(i)}};
  endfunction

  task automatic push(input lc3b_wb_adr a, input lc3b_line d);
    vb_push      = 1'b1;
    vb_push_adr  = a;
    vb_push_data = d;
    tick();
    vb_push = 1'b0;
  endtask

  task automatic wait_write(input string tag);
    int n = 0;
    while (!pmem_write && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_wait"}, 128'(pmem_write), 128'(1));
  endtask

  task automatic drain_one(input string tag, input lc3b_wb_adr a, input lc3b_line d);
    wait_write(tag);
    check({tag, "_addr"}, 128'(pmem_address), 128'({a, 4'b0000}));
    check({tag, "_data"}, pmem_wdata, d);
    $display("write addr=%h data=%h", pmem_address, pmem_wdata);
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    check({tag, "_bubble"}, 128'(pmem_write), 128'(0));
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_write", 128'(pmem_write), 0);
    check("rst_addr",  128'(pmem_address), 0);
    check("rst_wdata", pmem_wdata, 0);
    check("rst_full",  128'(vb_full), 0);
    check("rst_empty", 128'(vb_empty), 1);
    check("rst_hit",   128'(lk_hit), 0);
    check("rst_lkdata", lk_data, 0);
    rst = 1'b0;
    tick();

    // Single push: visible at N+1, write at N+2
    vb_push = 1'b1; vb_push_adr = 12'h0A3; vb_push_data = DATA_1; lk_adr = 12'h0A3;
    #1;
    check("t1_no_fwd", 128'(lk_hit), 0);
    tick();
    vb_push = 1'b0;
    check("t1_hit", 128'(lk_hit), 1);
    check("t1_lkdata", lk_data, DATA_1);
    check("t1_n1_nowrite", 128'(pmem_write), 0);
    tick();
    check("t1_n2_write", 128'(pmem_write), 1);
    check("t1_addr", 128'(pmem_address), 128'(16'h0A30));
    check("t1_wdata", pmem_wdata, DATA_1);
    $display("write addr=%h data=%h", pmem_address, pmem_wdata);
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    check("t1_empty", 128'(vb_empty), 1);
    check("t1_bubble", 128'(pmem_write), 0);
    check("t1_popped_miss", 128'(lk_hit), 0);

    // Fill to full under hold, drop 5th push, drain in order
    drain_hold = 1'b1;
    for (int i = 0; i < 4; i++) push(12'h100 + 12'(i), pat(i));
    check("t2_full", 128'(vb_full), 1);
    push(12'h104, DATA_X);
    lk_adr = 12'h104;
    #1;
    check("t2_drop_miss", 128'(lk_hit), 0);
    check("t2_still_full", 128'(vb_full), 1);
    check("t2_held", 128'(pmem_write), 0);
    lk_adr = 12'h101;
    #1;
    check("t2_lk101", lk_data, pat(1));
    drain_hold = 1'b0;
    for (int i = 0; i < 4; i++) drain_one("t2_drain", 12'h100 + 12'(i), pat(i));
    check("t2_empty", 128'(vb_empty), 1);

    // Coalesce into the queued entry
    drain_hold = 1'b1;
    push(12'h010, DATA_A);
    push(12'h010, DATA_B);
    lk_adr = 12'h010;
    #1;
    check("t3_hit", 128'(lk_hit), 1);
    check("t3_lkdata", lk_data, DATA_B);
    drain_hold = 1'b0;
    drain_one("t3_drain", 12'h010, DATA_B);
    check("t3_single_write_empty", 128'(vb_empty), 1);

    // Re-push of the head while it drains appends a new entry
    push(12'h020, DATA_X);
    wait_write("t4");
    check("t4_first_data", pmem_wdata, DATA_X);
    vb_push = 1'b1; vb_push_adr = 12'h020; vb_push_data = DATA_C; lk_adr = 12'h020;
    tick();
    vb_push = 1'b0;
    check("t4_stable_write", 128'(pmem_write), 1);
    check("t4_stable_data", pmem_wdata, DATA_X);
    check("t4_newest_wins", lk_data, DATA_C);
    $display("write addr=%h data=%h", pmem_address, pmem_wdata);
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    check("t4_bubble", 128'(pmem_write), 0);
    drain_one("t4_second", 12'h020, DATA_C);
    check("t4_empty", 128'(vb_empty), 1);

    // Push and pop together at full: push dropped, next push accepted
    drain_hold = 1'b1;
    for (int i = 0; i < 4; i++) push(12'h200 + 12'(i), pat(8 + i));
    check("t5_full", 128'(vb_full), 1);
    drain_hold = 1'b0;
    wait_write("t5");
    check("t5_addr", 128'(pmem_address), 128'(16'h2000));
    vb_push = 1'b1; vb_push_adr = 12'h204; vb_push_data = DATA_A; pmem_resp = 1'b1;
    tick();
    vb_push = 1'b0; pmem_resp = 1'b0;
    check("t5_not_full", 128'(vb_full), 0);
    lk_adr = 12'h204;
    #1;
    check("t5_dropped", 128'(lk_hit), 0);
    push(12'h205, DATA_B);
    lk_adr = 12'h205;
    #1;
    check("t5_accepted", 128'(lk_hit), 1);
    check("t5_full_again", 128'(vb_full), 1);

    // Reset in the middle of a drain
    wait_write("t6");
    lk_adr = 12'h201;
    #2;
    rst = 1'b1;
    #1;
    check("t6_write", 128'(pmem_write), 0);
    check("t6_addr", 128'(pmem_address), 0);
    check("t6_wdata", pmem_wdata, 0);
    check("t6_empty", 128'(vb_empty), 1);
    check("t6_full", 128'(vb_full), 0);
    check("t6_hit", 128'(lk_hit), 0);
    check("t6_lkdata", lk_data, 0);
    tick();
    rst = 1'b0;
    tick();
    check("t6_post_empty", 128'(vb_empty), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lc3b_victim_buffer.md
# lc3b_victim_buffer

Write-back victim buffer between the L1 data cache and physical memory. Evicted dirty lines (12-bit line address, 128-bit data) are queued here so the cache can start its miss fill at once. Queued lines drain to memory in FIFO order when memory is free. Queued lines also stay visible to the cache through a combinational lookup port, so a refetch of a just-evicted line never reads stale memory.

## Interface
- DEPTH, 4, number of line entries (2..8).
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- vb_push  in  1  cache offers an evicted line this cycle.
- vb_push_adr  in  lc3b_wb_adr  line address (byte address [15:4]).
- vb_push_data  in  lc3b_line  line data.
- vb_full  out  1  no free entry; a push while high is dropped.
- vb_empty  out  1  no valid entries and no drain in progress.
- lk_adr  in  lc3b_wb_adr  lookup line address from cache miss logic.
- lk_hit  out  1  some valid entry matches lk_adr (combinational).
- lk_data  out  lc3b_line  data of the matching entry; 0 when no hit.
- drain_hold  in  1  cache owns memory for a fill; no new drain may start.
- pmem_write  out  1  write request to memory.
- pmem_address  out  lc3b_word  {head adr, 4'b0000}.
- pmem_wdata  out  lc3b_line  head entry data.
- pmem_resp  in  1  memory completed the write.

## Operation
- Storage: circular FIFO of DEPTH entries {valid, adr, data}. Head and tail pointers are clog2(DEPTH) bits and wrap modulo DEPTH. Count is clog2(DEPTH)+1 bits.
- Push, accepted when vb_full is 0:
  - If a valid non-head entry has adr equal to vb_push_adr, overwrite that entry's data (coalesce). Count is unchanged.
  - If the match is the head entry and state is DRAIN, append a new entry instead.
  - Otherwise, write to the tail and increment the tail.
  - A push attempted while full is ignored. The state is untouched.
- Lookup: searches registered valid entries only. On multiple matches, the newest (closest to tail) wins. A push in the same cycle is not forwarded. The head entry being drained still hits until it is popped.
- FSM states:
  - IDLE: if count>0 and drain_hold is 0, go to DRAIN next cycle.
  - DRAIN: pmem_write=1 with head address/data held stable until pmem_resp. On pmem_resp, pop the head (clear valid, increment head) and return to IDLE.
  - drain_hold rising during DRAIN does not abort the drain.
- Simultaneous push and pop: both take effect and count is unchanged. A push to the slot freed by the pop is legal only on the next cycle, because vb_full is evaluated on the current count.
- vb_full = (count==DEPTH). vb_empty = (count==0).

## Timing
- Reset: all valid=0, head=tail=count=0, state IDLE. Outputs: pmem_write=0, pmem_address=0, pmem_wdata=0, vb_full=0, vb_empty=1, lk_hit=0, lk_data=0.
- Reset asserted mid-drain aborts immediately. The queued lines are lost by definition.
- Push to visible: an entry pushed in cycle N is visible to lookup and to the drain logic from cycle N+1.
- Minimum drain latency: push in cycle N, IDLE→DRAIN at the edge ending N+1, pmem_write high in N+2.
- One idle bubble after each pmem_resp. pmem_write is low for at least one cycle between writes.
- pmem_* outputs are registered-stable throughout DRAIN. pmem_write never drops before pmem_resp.

## Structure
- Types to add to the shared package:
  - lc3b_wb_adr and lc3b_line (already present).
  - New enum lc3b_vb_state {vb_idle, vb_drain}.
- Natural sub-module: lc3b_vb_match, a combinational DEPTH-way address compare with newest-first priority select. It returns hit, index and data, and is used by both the lookup port and push coalescing.

## Test plan
- Reset then single push: push adr 12'h0A3, data 128'hDEAD..BEEF. Expect lk_hit=1 for 12'h0A3 next cycle, pmem_write in cycle N+2 with pmem_address=16'h0A30, and vb_empty=1 after pmem_resp.
- Fill to full with drain_hold=1: push 4 distinct lines, so vb_full=1. A 5th push is dropped and lookup of its address misses. Release hold, and the lines drain in push order.
- Coalesce: push 12'h010 data A, then 12'h010 data B while held. Count stays 1. Lookup returns B and memory receives only B.
- Head-in-drain re-push: while 12'h020 is draining, push 12'h020 data C. Two writes occur: old data, then C.
- Simultaneous push and pop at count=DEPTH: pmem_resp in the same cycle as a push while vb_full=1. The push is dropped, count becomes DEPTH-1, and a push the next cycle is accepted.
- Reset mid-drain: assert rst while pmem_write=1. Outputs return to reset values asynchronously and vb_empty=1.
